// File: rtl/dadda_acc.sv
// Streaming multiply-accumulate back end: registers each Dadda product, sums LEN of them and hands off the result.
// Optional build macro DADDA_ACC_SAT_EN makes acc saturate instead of wrapping.
module dadda_acc #(
  parameter int LEN   = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32:0]      prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  localparam int               CNT_W = $clog2(LEN) + 1;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_e           state_q, state_d;
  logic [32:0]      p_q, p_d;
  logic             p_v_q, p_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             beat;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign acc_ovf   = ovf_q;

  assign beat    = in_valid && in_ready;
  assign cnt_inc = cnt_q + 1'b1;
  // One extra bit so the carry out of the accumulator is visible for the overflow flag.
  assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 33){1'b0}}, p_q};

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    p_d     = p_q;
    p_v_d   = 1'b0;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (beat) begin
      p_d   = prod;
      p_v_d = 1'b1;
      cnt_d = cnt_inc;
    end

    if (p_v_q) begin
`ifdef DADDA_ACC_SAT_EN
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
      ovf_d = ovf_q | sum[ACC_W];
    end

    unique case (state_q)
      IDLE, ACCUM: if (beat) state_d = (cnt_inc == LEN_C) ? DRAIN : ACCUM;
      DRAIN:       state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default:     state_d = IDLE;
    endcase

    // Abort wins over everything, including a beat offered in the same cycle.
    if (clr) begin
      state_d = IDLE;
      p_v_d   = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      p_v_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      p_q     <= p_d;
      p_v_q   <= p_v_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
